// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit.
// Holds forwarding select encodings, the hazard FSM state type and
// the width of the stall-length down-counter.
package fwd_pkg;

  // Operand source selects driven to the EX-stage operand muxes
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Stall-length down-counter width; bounds LOAD_LAT to 1..15
  localparam int unsigned LAT_CNT_W = 4;

  // Load-use hazard FSM states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/fwd_sel_lane.sv
// Single-operand forwarding select.
// Picks EX/MEM over MEM/WB over the register file; register 0 never forwards.
module fwd_sel_lane
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  output logic [1:0]        sel
);

  logic exmem_hit;
  logic memwb_hit;

  // Match each older producer against this operand, then resolve priority
  always_comb begin
    exmem_hit = src_used && exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src);
    memwb_hit = src_used && memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src);
    sel       = FWD_RF;
    if (exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Drives per-operand forwarding selects for NUM_SRC EX-stage operands and
// stalls IF/ID + PC (bubbling ID/EX) for LOAD_LAT cycles on a load-use hazard.
// Optional stall performance counter enabled by macro FWD_STALL_CNT_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] idex_src,
  input  logic [NUM_SRC-1:0]        idex_src_used,
  input  logic [NUM_SRC*REG_AW-1:0] ifid_src,
  input  logic [NUM_SRC-1:0]        ifid_src_used,
  input  logic [REG_AW-1:0]         idex_rd,
  input  logic                      idex_mem_read,
  input  logic [REG_AW-1:0]         exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic [REG_AW-1:0]         memwb_rd,
  input  logic                      memwb_reg_write,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      idex_bubble,
  output logic [CNT_W-1:0]          stall_cnt
);

  // Remaining-cycles value loaded on hazard entry: the IDLE cycle that
  // detects the hazard is itself the first stall cycle.
  localparam logic [LAT_CNT_W-1:0] STALL_INIT =
    (LOAD_LAT > 1) ? LAT_CNT_W'(LOAD_LAT - 2) : '0;

  fwd_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic                 src_hit;
  logic                 load_use;

  // One forwarding select lane per EX-stage source operand
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_sel_lane #(
      .REG_AW (REG_AW)
    ) u_lane (
      .src             (idex_src[i*REG_AW +: REG_AW]),
      .src_used        (idex_src_used[i]),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .sel             (fwd_sel[2*i +: 2])
    );
  end

  // Detect an ID-stage operand that needs the result of a load now in EX
  always_comb begin
    src_hit = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (ifid_src_used[j] && (ifid_src[j*REG_AW +: REG_AW] == idex_rd)) begin
        src_hit = 1'b1;
      end
    end
    load_use = idex_mem_read && (idex_rd != '0) && src_hit;
  end

  // Hazard FSM next-state and stall outputs; flush overrides everything
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    if (flush) begin
      state_d     = ST_IDLE;
      lat_cnt_d   = '0;
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d   = ST_STALL;
              lat_cnt_d = STALL_INIT;
            end
          end
        end
        ST_STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (lat_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            lat_cnt_d = lat_cnt_q - 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          lat_cnt_d = '0;
        end
      endcase
    end
  end

  // Hazard FSM state and stall-length counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count stalled cycles, saturating at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit (NUM_SRC=3, LOAD_LAT=3).
// Driver pushes expected outputs from a reference model; monitor pops and
// compares on the falling edge.
module tb_fwd_hazard_unit;

  localparam int NS  = 3;
  localparam int AW  = 5;
  localparam int LAT = 3;
  localparam int CW  = 16;

  typedef struct {
    logic [NS*AW-1:0] idex_src;
    logic [NS-1:0]    idex_used;
    logic [NS*AW-1:0] ifid_src;
    logic [NS-1:0]    ifid_used;
    logic [AW-1:0]    idex_rd;
    logic             mem_read;
    logic [AW-1:0]    exmem_rd;
    logic             exmem_w;
    logic [AW-1:0]    memwb_rd;
    logic             memwb_w;
    logic             flush;
  } stim_t;

  typedef struct {
    logic [2*NS-1:0] fwd;
    logic            pc;
    logic            ifid;
    logic            bub;
    logic [CW-1:0]   cnt;
    int              cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS*AW-1:0] idex_src, ifid_src;
  logic [NS-1:0]    idex_src_used, ifid_src_used;
  logic [AW-1:0]    idex_rd, exmem_rd, memwb_rd;
  logic             idex_mem_read, exmem_reg_write, memwb_reg_write, flush;
  logic [2*NS-1:0]  fwd_sel;
  logic             pc_write, ifid_write, idex_bubble;
  logic [CW-1:0]    stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;

  exp_t sb[$];

  // Reference model state: stall cycles still owed and stall count
  int          stall_left, nxt_stall_left;
  int unsigned cnt_model, nxt_cnt;

  fwd_hazard_unit #(
    .NUM_SRC  (NS),
    .REG_AW   (AW),
    .LOAD_LAT (LAT),
    .CNT_W    (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .idex_src        (idex_src),
    .idex_src_used   (idex_src_used),
    .ifid_src        (ifid_src),
    .ifid_src_used   (ifid_src_used),
    .idex_rd         (idex_rd),
    .idex_mem_read   (idex_mem_read),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .flush           (flush),
    .fwd_sel         (fwd_sel),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_bubble     (idex_bubble),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s.idex_src = '0; s.idex_used = '0; s.ifid_src = '0; s.ifid_used = '0;
    s.idex_rd = '0; s.mem_read = 1'b0; s.exmem_rd = '0; s.exmem_w = 1'b0;
    s.memwb_rd = '0; s.memwb_w = 1'b0; s.flush = 1'b0;
    return s;
  endfunction

  function automatic stim_t hazard_stim();
    stim_t s = zero_stim();
    s.mem_read  = 1'b1;
    s.idex_rd   = 5'd8;
    s.ifid_src  = 15'd8;   // operand 0 = r8
    s.ifid_used = 3'b001;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    idex_src = s.idex_src; idex_src_used = s.idex_used;
    ifid_src = s.ifid_src; ifid_src_used = s.ifid_used;
    idex_rd = s.idex_rd; idex_mem_read = s.mem_read;
    exmem_rd = s.exmem_rd; exmem_reg_write = s.exmem_w;
    memwb_rd = s.memwb_rd; memwb_reg_write = s.memwb_w;
    flush = s.flush;
  endtask

  // Expected response for one cycle of stimulus, plus next model state
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [AW-1:0] a;
    bit lu = 0;
    for (int i = 0; i < NS; i++) begin
      a = s.idex_src[i*AW +: AW];
      if (s.idex_used[i] && s.exmem_w && s.exmem_rd != 0 && s.exmem_rd == a)
        e.fwd[2*i +: 2] = 2'b10;
      else if (s.idex_used[i] && s.memwb_w && s.memwb_rd != 0 && s.memwb_rd == a)
        e.fwd[2*i +: 2] = 2'b01;
      else
        e.fwd[2*i +: 2] = 2'b00;
      if (s.ifid_used[i] && s.ifid_src[i*AW +: AW] == s.idex_rd) lu = 1;
    end
    lu = lu && s.mem_read && (s.idex_rd != 0);
    if (s.flush) begin
      e.pc = 1; e.ifid = 1; e.bub = 1; nxt_stall_left = 0;
    end else if (stall_left > 0) begin
      e.pc = 0; e.ifid = 0; e.bub = 1; nxt_stall_left = stall_left - 1;
    end else if (lu) begin
      e.pc = 0; e.ifid = 0; e.bub = 1; nxt_stall_left = LAT - 1;
    end else begin
      e.pc = 1; e.ifid = 1; e.bub = 0; nxt_stall_left = 0;
    end
`ifdef FWD_STALL_CNT_EN
    e.cnt = CW'(cnt_model);
`else
    e.cnt = '0;
`endif
    nxt_cnt = (!e.pc && cnt_model < 32'hFFFF) ? cnt_model + 1 : cnt_model;
    e.cyc = cyc_no;
    return e;
  endfunction

  task automatic cycle(input stim_t s);
    @(posedge clk);
    stall_left = nxt_stall_left;
    cnt_model  = nxt_cnt;
    #1;
    apply(s);
    cyc_no++;
    sb.push_back(model(s));
  endtask

  // Monitor: compare DUT outputs against the oldest expected entry
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("fwd_sel c%0d", e.cyc), 32'(fwd_sel), 32'(e.fwd));
      chk($sformatf("pc_write c%0d", e.cyc), 32'(pc_write), 32'(e.pc));
      chk($sformatf("ifid_write c%0d", e.cyc), 32'(ifid_write), 32'(e.ifid));
      chk($sformatf("idex_bubble c%0d", e.cyc), 32'(idex_bubble), 32'(e.bub));
      chk($sformatf("stall_cnt c%0d", e.cyc), 32'(stall_cnt), 32'(e.cnt));
    end
  end

  task automatic model_reset();
    stall_left = 0; nxt_stall_left = 0;
    cnt_model = 0;  nxt_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst = 1'b0;
    apply(zero_stim());
    model_reset();
    #3;
    chk("reset pc_write", 32'(pc_write), 1);
    chk("reset ifid_write", 32'(ifid_write), 1);
    chk("reset idex_bubble", 32'(idex_bubble), 0);
    chk("reset fwd_sel", 32'(fwd_sel), 0);
    chk("reset stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk); rst = 1'b1;

    // EX/MEM priority on operand 1
    s = zero_stim();
    s.idex_src = {5'd0, 5'd5, 5'd0}; s.idex_used = 3'b111;
    s.exmem_rd = 5'd5; s.exmem_w = 1; s.memwb_rd = 5'd5; s.memwb_w = 1;
    cycle(s);
    // MEM/WB only on operand 2, EX/MEM on operand 0
    s = zero_stim();
    s.idex_src = {5'd9, 5'd4, 5'd3}; s.idex_used = 3'b111;
    s.exmem_rd = 5'd3; s.exmem_w = 1; s.memwb_rd = 5'd9; s.memwb_w = 1;
    cycle(s);
    // Register 0 never forwarded
    s = zero_stim();
    s.idex_used = 3'b111; s.exmem_w = 1; s.memwb_w = 1;
    cycle(s);
    // Unused operands never forwarded
    s = zero_stim();
    s.idex_src = {5'd7, 5'd7, 5'd7}; s.idex_used = 3'b000;
    s.exmem_rd = 5'd7; s.exmem_w = 1; s.memwb_rd = 5'd7; s.memwb_w = 1;
    cycle(s);
    // Load-use: stall exactly LAT cycles then resume
    cycle(hazard_stim());
    for (int i = 0; i < LAT + 2; i++) cycle(zero_stim());
    // Flush in second stall cycle
    cycle(hazard_stim());
    s = hazard_stim(); s.flush = 1;
    cycle(s);
    cycle(zero_stim());
    cycle(zero_stim());
    // Back-to-back hazard held across stall end
    for (int i = 0; i < 2 * LAT + 1; i++) cycle(hazard_stim());
    cycle(zero_stim());
    // Hazard on rd=0 must not stall
    s = hazard_stim(); s.idex_rd = '0; s.ifid_src = '0;
    cycle(s);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      s.idex_src  = '0;
      s.ifid_src  = '0;
      for (int i = 0; i < NS; i++) begin
        s.idex_src[i*AW +: AW] = AW'($urandom_range(0, 3));
        s.ifid_src[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      s.idex_used = NS'($urandom);
      s.ifid_used = NS'($urandom);
      s.idex_rd   = AW'($urandom_range(0, 3));
      s.mem_read  = 1'($urandom_range(0, 1));
      s.exmem_rd  = AW'($urandom_range(0, 3));
      s.exmem_w   = 1'($urandom);
      s.memwb_rd  = AW'($urandom_range(0, 3));
      s.memwb_w   = 1'($urandom);
      s.flush     = ($urandom_range(0, 9) == 0);
      cycle(s);
    end
    cycle(zero_stim());
    cycle(zero_stim());
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset during a stall
    @(posedge clk); #1;
    apply(hazard_stim());
    @(posedge clk); #2;
    apply(zero_stim());
    #1;
    chk("in stall pc_write", 32'(pc_write), 0);
    rst = 1'b0;
    #1;
    chk("async rst pc_write", 32'(pc_write), 1);
    chk("async rst ifid_write", 32'(ifid_write), 1);
    chk("async rst idex_bubble", 32'(idex_bubble), 0);
    chk("async rst fwd_sel", 32'(fwd_sel), 0);
    chk("async rst stall_cnt", 32'(stall_cnt), 0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle(zero_stim());
    cycle(hazard_stim());
    cycle(zero_stim());
    cycle(zero_stim());
    cycle(zero_stim());
    cycle(zero_stim());
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
